// File: rtl/alu_pkg.sv
// Shared types for the RV64I ALU scheduler: opcode fields, the supported
// {ALUOp, ALUControl} codes and the scheduler FSM states.
package alu_pkg;

  typedef logic [1:0] alu_op_t;
  typedef logic [3:0] alu_ctl_t;

  localparam logic [5:0] CODE_LS_ADD = 6'b00_0010;
  localparam logic [5:0] CODE_BR_SUB = 6'b01_0110;
  localparam logic [5:0] CODE_ADD    = 6'b10_0010;
  localparam logic [5:0] CODE_SUB    = 6'b10_0110;
  localparam logic [5:0] CODE_AND    = 6'b10_0000;
  localparam logic [5:0] CODE_OR     = 6'b10_0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_sched_state_e;

  typedef struct packed {
    logic [63:0] data1;
    logic [63:0] data2;
    alu_op_t     aluop;
    alu_ctl_t    aluctl;
  } alu_req_t;

  function automatic logic code_supported(input alu_op_t op, input alu_ctl_t ctl);
    logic [5:0] c;
    c = {op, ctl};
    return (c == CODE_LS_ADD) || (c == CODE_BR_SUB) || (c == CODE_ADD) ||
           (c == CODE_SUB) || (c == CODE_AND) || (c == CODE_OR);
  endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Request / ALU / response bundle of the ALU scheduler. The slave modport is
// the scheduler's view; master is the surrounding core (requesters, ALU, consumer).
interface alu_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0][63:0] req_data1_i;
  logic [NUM_REQ-1:0][63:0] req_data2_i;
  logic [NUM_REQ-1:0][1:0]  req_aluop_i;
  logic [NUM_REQ-1:0][3:0]  req_aluctl_i;

  logic [63:0] alu_data1_o;
  logic [63:0] alu_data2_o;
  logic [1:0]  alu_aluop_o;
  logic [3:0]  alu_aluctl_o;
  logic [63:0] alu_result_i;
  logic        alu_zero_i;

  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [ID_W-1:0] rsp_id_o;
  logic [63:0]     rsp_result_o;
  logic            rsp_zero_o;
  logic            rsp_err_o;

  modport slave (
    input  req_valid_i, req_data1_i, req_data2_i, req_aluop_i, req_aluctl_i,
    output req_ready_o,
    output alu_data1_o, alu_data2_o, alu_aluop_o, alu_aluctl_o,
    input  alu_result_i, alu_zero_i,
    output rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o,
    input  rsp_ready_i
  );

  modport master (
    output req_valid_i, req_data1_i, req_data2_i, req_aluop_i, req_aluctl_i,
    input  req_ready_o,
    input  alu_data1_o, alu_data2_o, alu_aluop_o, alu_aluctl_o,
    output alu_result_i, alu_zero_i,
    input  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o,
    output rsp_ready_i
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  logic [ID_W-1:0] k;
  logic            hit;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    k   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (req[k]) begin
        idx = k;
        hit = 1'b1;
      end
    end
    any = hit & en;
    if (any) gnt[idx] = 1'b1;
  end
endmodule

// File: rtl/alu_scheduler.sv
// Round-robin sharing of the single 64-bit ALU between NUM_REQ requesters.
// Optional opcode screening: define ALU_SCHED_OPCHK_EN.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input logic            clk_i,
  input logic            rst_i,
  alu_scheduler_if.slave bus
);
  alu_sched_state_e   state, state_nxt;
  logic [ID_W-1:0]    ptr, gnt_idx, id_q;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any, grant_en, code_ok;
  alu_req_t           sel, op_q;

  logic [ID_W-1:0] rsp_id_q;
  logic [63:0]     rsp_result_q;
  logic            rsp_zero_q;

  // Grants only happen while the response slot is free (or being freed).
  assign grant_en = !rst_i && (state == IDLE || (state == RESP && bus.rsp_ready_i));

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (bus.req_valid_i),
    .ptr (ptr),
    .en  (grant_en),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign bus.req_ready_o = gnt;

  always_comb begin
    sel.data1  = bus.req_data1_i[gnt_idx];
    sel.data2  = bus.req_data2_i[gnt_idx];
    sel.aluop  = bus.req_aluop_i[gnt_idx];
    sel.aluctl = bus.req_aluctl_i[gnt_idx];
  end

`ifdef ALU_SCHED_OPCHK_EN
  assign code_ok = code_supported(sel.aluop, sel.aluctl);
`else
  assign code_ok = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt_any) state_nxt = code_ok ? EXEC : RESP;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready_i) state_nxt = gnt_any ? (code_ok ? EXEC : RESP) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        ptr <= '0;
    else if (gnt_any) ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // The operand register is the ALU input bus; it reads zero outside EXEC.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q <= '0;
      id_q <= '0;
    end else if (gnt_any && code_ok) begin
      op_q <= sel;
      id_q <= gnt_idx;
    end else begin
      op_q <= '0;
    end
  end

  assign bus.alu_data1_o  = op_q.data1;
  assign bus.alu_data2_o  = op_q.data2;
  assign bus.alu_aluop_o  = op_q.aluop;
  assign bus.alu_aluctl_o = op_q.aluctl;

`ifdef ALU_SCHED_OPCHK_EN
  logic rsp_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id_q     <= id_q;
      rsp_result_q <= bus.alu_result_i;
      rsp_zero_q   <= bus.alu_zero_i;
      rsp_err_q    <= 1'b0;
    end else if (gnt_any && !code_ok) begin
      rsp_id_q     <= gnt_idx;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b1;
    end
  end

  assign bus.rsp_err_o = rsp_err_q;
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id_q     <= id_q;
      rsp_result_q <= bus.alu_result_i;
      rsp_zero_q   <= bus.alu_zero_i;
    end
  end

  assign bus.rsp_err_o = 1'b0;
`endif

  assign bus.rsp_valid_o  = (state == RESP);
  assign bus.rsp_id_o     = rsp_id_q;
  assign bus.rsp_result_o = rsp_result_q;
  assign bus.rsp_zero_o   = rsp_zero_q;
endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler with four requesters and a behavioural ALU.
module tb_alu_scheduler;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  c;
  } stim_t;

  typedef struct {
    int          id;
    logic [63:0] res;
    logic        z;
    logic        e;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_scheduler_if #(.NUM_REQ(N)) bus ();
  alu_scheduler #(.NUM_REQ(N)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b, input logic [5:0] c);
    case (c)
      6'b000010, 6'b100010: return a + b;
      6'b010110, 6'b100110: return a - b;
      6'b100000:            return a & b;
      6'b100001:            return a | b;
      default:              return 64'd0;
    endcase
  endfunction

  function automatic bit sup(input logic [5:0] c);
    return c == 6'b000010 || c == 6'b010110 || c == 6'b100010 ||
           c == 6'b100110 || c == 6'b100000 || c == 6'b100001;
  endfunction

  // Behavioural combinational ALU.
  always_comb begin
    bus.alu_result_i = alu_f(bus.alu_data1_o, bus.alu_data2_o, {bus.alu_aluop_o, bus.alu_aluctl_o});
    bus.alu_zero_i   = (bus.alu_result_i == 64'd0);
  end

  stim_t       sq[N][$];
  exp_t        sb[$];
  logic [N-1:0] acc = '0;
  int          acc_id[$];
  int          acc_cyc[$];

  // Requester driver: holds valid/payload until accepted, then loads the next op.
  initial begin
    stim_t s;
    bus.req_valid_i  = '0;
    bus.req_data1_i  = '0;
    bus.req_data2_i  = '0;
    bus.req_aluop_i  = '0;
    bus.req_aluctl_i = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          bus.req_valid_i[IW'(i)] = 1'b0;
        end else if (acc[i] || !bus.req_valid_i[IW'(i)]) begin
          if (sq[i].size() > 0) begin
            s = sq[i].pop_front();
            bus.req_data1_i[IW'(i)]  = s.a;
            bus.req_data2_i[IW'(i)]  = s.b;
            bus.req_aluop_i[IW'(i)]  = s.c[5:4];
            bus.req_aluctl_i[IW'(i)] = s.c[3:0];
            bus.req_valid_i[IW'(i)]  = 1'b1;
          end else begin
            bus.req_valid_i[IW'(i)] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: grant model, ALU-input expectation, response scoreboard.
  logic [IW-1:0] mptr = '0;
  bit            x_pend = 0;
  stim_t         xs;
  bit            r_pend = 0;
  logic [IW-1:0] h_id;
  logic [63:0]   h_res;
  logic          h_z, h_e;

  always @(negedge clk) begin
    exp_t          e;
    int            eid;
    logic [IW-1:0] j;
    logic [IW-1:0] g;
    stim_t         s;
    if (rst) begin
      acc = '0; mptr = '0; sb.delete(); x_pend = 0; r_pend = 0;
    end else begin
      if (x_pend) begin
        chk("alu_d1", bus.alu_data1_o, xs.a);
        chk("alu_d2", bus.alu_data2_o, xs.b);
        chk("alu_code", 64'({bus.alu_aluop_o, bus.alu_aluctl_o}), 64'(xs.c));
      end else begin
        chk("alu_idle", 64'(bus.alu_data1_o | bus.alu_data2_o |
                            64'({bus.alu_aluop_o, bus.alu_aluctl_o})), 64'd0);
      end
      x_pend = 0;

      if (bus.rsp_valid_o) begin
        if (r_pend) begin
          chk("hold_id", 64'(bus.rsp_id_o), 64'(h_id));
          chk("hold_res", bus.rsp_result_o, h_res);
          chk("hold_zero", 64'(bus.rsp_zero_o), 64'(h_z));
          chk("hold_err", 64'(bus.rsp_err_o), 64'(h_e));
        end else if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 64'(bus.rsp_id_o), 64'(e.id));
          chk("rsp_res", bus.rsp_result_o, e.res);
          chk("rsp_zero", 64'(bus.rsp_zero_o), 64'(e.z));
          chk("rsp_err", 64'(bus.rsp_err_o), 64'(e.e));
          chk("latency", 64'(cyc - e.cyc), e.e ? 64'd1 : 64'd2);
        end
        if (!bus.rsp_ready_i) chk("bp_no_ready", 64'(bus.req_ready_o), 64'd0);
        else if (|bus.req_valid_i) chk("b2b_grant", 64'(|bus.req_ready_o), 64'd1);
        r_pend = !bus.rsp_ready_i;
        h_id = bus.rsp_id_o; h_res = bus.rsp_result_o; h_z = bus.rsp_zero_o; h_e = bus.rsp_err_o;
      end else begin
        r_pend = 0;
      end

      acc = bus.req_ready_o & bus.req_valid_i;
      if (|bus.req_ready_o) begin
        eid = -1;
        for (int k = 0; k < N; k++) begin
          j = IW'((int'(mptr) + k) % N);
          if (eid < 0 && bus.req_valid_i[j]) eid = int'(j);
        end
        g = IW'(eid);
        chk("grant", 64'(bus.req_ready_o), 64'(1) << eid);
        s.a = bus.req_data1_i[g];
        s.b = bus.req_data2_i[g];
        s.c = {bus.req_aluop_i[g], bus.req_aluctl_i[g]};
        e.id  = eid;
        e.cyc = cyc;
`ifdef ALU_SCHED_OPCHK_EN
        e.e = !sup(s.c);
`else
        e.e = 1'b0;
`endif
        e.res = e.e ? 64'd0 : alu_f(s.a, s.b, s.c);
        e.z   = e.e ? 1'b0 : (e.res == 64'd0);
        sb.push_back(e);
        if (!e.e) begin x_pend = 1; xs = s; end
        mptr = IW'((eid + 1) % N);
        acc_id.push_back(eid);
        acc_cyc.push_back(cyc);
      end
    end
  end

  function automatic bit busy();
    bit b;
    b = (bus.req_valid_i != '0) || (sb.size() != 0) || bus.rsp_valid_o;
    for (int i = 0; i < N; i++) if (sq[i].size() != 0) b = 1;
    return b;
  endfunction

  task automatic drain(input int maxc);
    int n = 0;
    while (busy() && n < maxc) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", 64'(n >= maxc), 64'd0);
    repeat (2) @(posedge clk);
  endtask

  function automatic stim_t mk(input logic [63:0] a, input logic [63:0] b, input logic [5:0] c);
    stim_t s;
    s.a = a; s.b = b; s.c = c;
    return s;
  endfunction

  int n;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_id", 64'(bus.rsp_id_o), 64'd0);
    chk("rst_res", bus.rsp_result_o, 64'd0);
    chk("rst_zero", 64'(bus.rsp_zero_o), 64'd0);
    chk("rst_err", 64'(bus.rsp_err_o), 64'd0);
    chk("rst_alu", 64'(bus.alu_data1_o | bus.alu_data2_o), 64'd0);
    chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
    rst = 1'b0;

    // Single add, then branch compare with equal operands.
    sq[0].push_back(mk(64'd5, 64'd7, 6'b100010));
    drain(50);
    sq[1].push_back(mk(64'h1234, 64'h1234, 6'b010110));
    drain(50);

    // Mixed operations on all requesters at once.
    sq[2].push_back(mk(64'hff00, 64'h0f0f, 6'b100000));
    sq[3].push_back(mk(64'hff00, 64'h0f0f, 6'b100001));
    sq[0].push_back(mk(64'd3, 64'd5, 6'b100110));
    sq[1].push_back(mk(64'hffff_ffff_ffff_ffff, 64'd1, 6'b000010));
    drain(100);

    // Backpressure: hold the consumer off for 5 cycles with a second request waiting.
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    sq[2].push_back(mk(64'd100, 64'd1, 6'b100010));
    sq[3].push_back(mk(64'd9, 64'd9, 6'b100110));
    n = 0;
    while (!bus.rsp_valid_o && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_wait_timeout", 64'(n >= 50), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    bus.rsp_ready_i = 1'b1;
    drain(100);

    // Reset during EXEC: nothing from the aborted op may surface.
    sq[1].push_back(mk(64'd1, 64'd1, 6'b100010));
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!acc[1] && n < 50);
    chk("rst_acc_timeout", 64'(acc[1]), 64'd1);
    @(posedge clk); #2;
    chk("exec_loaded", bus.alu_data1_o, 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("mid_rst_alu", 64'(bus.alu_data1_o | bus.alu_data2_o |
                           64'({bus.alu_aluop_o, bus.alu_aluctl_o})), 64'd0);
    chk("mid_rst_rsp", bus.rsp_result_o | 64'(bus.rsp_id_o) | 64'(bus.rsp_zero_o), 64'd0);
    chk("mid_rst_ready", 64'(bus.req_ready_o), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk); #2;
    chk("no_stale", 64'(bus.rsp_valid_o), 64'd0);

    // Fairness after reset: all four continuously valid, pointer back at 0.
    acc_id.delete();
    acc_cyc.delete();
    for (int i = 0; i < N; i++) begin
      sq[i].push_back(mk(64'(i * 10), 64'd1, 6'b100010));
      sq[i].push_back(mk(64'(i * 10), 64'd2, 6'b100110));
    end
    drain(200);
    chk("fair_count", 64'(acc_id.size()), 64'd8);
    if (acc_id.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("fair_order", 64'(acc_id[i]), 64'(exp_order[i]));
      for (int i = 0; i < 4; i++) chk("fair_rate", 64'(acc_cyc[i+1] - acc_cyc[i]), 64'd2);
    end

    // Unsupported code.
    sq[2].push_back(mk(64'd77, 64'd33, 6'b001111));
    drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
